icache_assoc: RTL and testbench

//  Parametrised N-way set-associative instruction cache between IF and the memory controller.
//  Hit returns the instruction word combinationally in the same cycle.

---
 rtl/icache_assoc_pkg.sv | 26 ++
 rtl/icache_victim_sel.sv | 46 ++++
 rtl/icache_assoc.sv | 240 ++++++++++++++++++++++++
 tb/tb_icache_assoc.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_assoc_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the boolean constants, word/address types and the fetch FSM state
// encodings used by icache_assoc and icache_victim_sel.
// The PFETCH encoding exists only when ICACHE_PREFETCH_EN is defined.
package icache_assoc_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [31:0]       addr_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef ICACHE_PREFETCH_EN
        ST_PFETCH = 2'd2,
`endif
        ST_FETCH  = 2'd1
    } state_t;

endpackage

// File: rtl/icache_victim_sel.sv
// Picks the way to fill in one set and the set's next round-robin pointer.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is committed.
//
// Ports:
//   valid    - valid bits of every way in the set
//   ptr      - current round-robin pointer of the set
//   fill_way - one-hot way to write
//   ptr_nxt  - pointer value to store after the fill
module icache_victim_sel
    import icache_assoc_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int PTR_W = 1
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [WAYS-1:0]  fill_way,
    output logic [PTR_W-1:0] ptr_nxt
);

    logic found;

    always_comb begin
        fill_way = '0;
        found    = FALSE;
        ptr_nxt  = ptr;
        // An empty way is always preferred and does not advance the pointer.
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[w] && !found) begin
                fill_way[w] = TRUE;
                found       = TRUE;
            end
        end
        // Set full: replace the pointed-to way and move the pointer on.
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ptr == PTR_W'(w)) begin
                    fill_way[w] = TRUE;
                end
            end
            ptr_nxt = (WAYS == 1) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with single outstanding line fill.
// Latency: hit data combinational in the request cycle; miss request registered next edge.
// Backpressure: rdy=0 freezes all state; cache_st blocks only new miss issue.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   rdy                   global ready (0 = hold everything)
//   cache_en/cache_st     IF request valid / IF stall
//   cache_rb              rollback, cancels a not-yet-issued prefetch
//   if_addr               fetch address (word aligned)
//   if_cache_hit/if_hit_word   combinational lookup result
//   mc_fc_ena/mc_fc_addr  registered line-fill request to the memory controller
//   mc_fc_done/mc_fc_line fill completion pulse and line data
// Optional feature: ICACHE_PREFETCH_EN adds next-line prefetch after a demand fill.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    input  logic                    cache_en,
    input  logic                    cache_st,
    input  logic                    cache_rb,
    input  logic [ADDR_W-1:0]       if_addr,
    output logic                    if_cache_hit,
    output logic [31:0]             if_hit_word,
    output logic                    mc_fc_ena,
    output logic [ADDR_W-1:0]       mc_fc_addr,
    input  logic                    mc_fc_done,
    input  logic [32*LINE_WORDS-1:0] mc_fc_line
);

    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef word_t [LINE_WORDS-1:0] line_t;

    // Storage. Only valid bits and victim pointers are reset.
    logic [SETS-1:0]  valid_q [WAYS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    line_t            data_q  [WAYS][SETS];
    logic [PTR_W-1:0] vptr_q  [SETS];

    state_t            state_q, state_d;
    logic              ena_q, ena_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // ---------------- IF lookup ----------------
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] if_idx;
    logic [WAYS-1:0]  hit_vec;
    line_t            hit_line;

    assign if_tag = if_addr[ADDR_W-1 -: TAG_W];
    assign if_idx = if_addr[OFF_W +: IDX_W];

    always_comb begin
        hit_vec  = '0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[w][if_idx] && (tag_q[w][if_idx] == if_tag);
            // At most one way matches, so OR-ing the gated lines selects it.
            if (hit_vec[w]) begin
                hit_line = hit_line | data_q[w][if_idx];
            end
        end
    end

    assign if_cache_hit = |hit_vec;

    generate
        if (LINE_WORDS > 1) begin : g_wsel
            logic [OFF_W-3:0] if_word;
            assign if_word     = if_addr[OFF_W-1:2];
            assign if_hit_word = hit_line[if_word];
        end else begin : g_wsel_single
            assign if_hit_word = hit_line[0];
        end
    endgenerate

    // ---------------- Fill path ----------------
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] f_idx;
    logic [WAYS-1:0]  f_valid;
    logic [WAYS-1:0]  fill_oh;
    logic [PTR_W-1:0] ptr_nxt;
    logic             fill_en;

    assign f_tag   = addr_q[ADDR_W-1 -: TAG_W];
    assign f_idx   = addr_q[OFF_W +: IDX_W];
    // done is meaningful only while a request is outstanding.
    assign fill_en = rdy && mc_fc_done && ena_q;

    always_comb begin
        f_valid = '0;
        for (int w = 0; w < WAYS; w++) begin
            f_valid[w] = valid_q[w][f_idx];
        end
    end

    icache_victim_sel #(
        .WAYS  (WAYS),
        .PTR_W (PTR_W)
    ) u_victim_sel (
        .valid    (f_valid),
        .ptr      (vptr_q[f_idx]),
        .fill_way (fill_oh),
        .ptr_nxt  (ptr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                vptr_q[s] <= '0;
            end
        end else if (fill_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (fill_oh[w]) begin
                    valid_q[w][f_idx] <= TRUE;
                end
            end
            vptr_q[f_idx] <= ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (fill_oh[w]) begin
                    tag_q[w][f_idx]  <= f_tag;
                    data_q[w][f_idx] <= mc_fc_line;
                end
            end
        end
    end

`ifdef ICACHE_PREFETCH_EN
    // ---------------- Next-line probe ----------------
    // L+1 always lands in a different set than L, so the probe sees
    // contents unaffected by the fill happening in the same cycle.
    logic [ADDR_W-1:0] pf_addr;
    logic [TAG_W-1:0]  pf_tag;
    logic [IDX_W-1:0]  pf_idx;
    logic              pf_hit;
    logic              unused_bits;

    assign pf_addr = addr_q + ADDR_W'(4 * LINE_WORDS);
    assign pf_tag  = pf_addr[ADDR_W-1 -: TAG_W];
    assign pf_idx  = pf_addr[OFF_W +: IDX_W];

    always_comb begin
        pf_hit = FALSE;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][pf_idx] && (tag_q[w][pf_idx] == pf_tag)) begin
                pf_hit = TRUE;
            end
        end
    end

    assign unused_bits = ^if_addr[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{if_addr[1:0], cache_rb};
`endif

    // ---------------- Request FSM ----------------
    always_comb begin
        state_d = state_q;
        ena_d   = ena_q;
        addr_d  = addr_q;
        if (rdy) begin
            case (state_q)
                ST_IDLE: begin
                    if (cache_en && !cache_st && !if_cache_hit) begin
                        state_d = ST_FETCH;
                        ena_d   = TRUE;
                        addr_d  = {if_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                ST_FETCH: begin
                    if (mc_fc_done) begin
                        ena_d   = FALSE;
                        state_d = ST_IDLE;
`ifdef ICACHE_PREFETCH_EN
                        if (!pf_hit && !cache_rb) begin
                            state_d = ST_PFETCH;
                        end
`endif
                    end
                end
`ifdef ICACHE_PREFETCH_EN
                // ena low: prefetch decided but not issued (rollback may drop it).
                // ena high: prefetch in flight, finishes like a demand fill.
                ST_PFETCH: begin
                    if (!ena_q) begin
                        if (cache_rb) begin
                            state_d = ST_IDLE;
                        end else begin
                            ena_d  = TRUE;
                            addr_d = pf_addr;
                        end
                    end else if (mc_fc_done) begin
                        ena_d   = FALSE;
                        state_d = ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ena_q   <= FALSE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ena_q   <= ena_d;
            addr_q  <= addr_d;
        end
    end

    assign mc_fc_ena  = ena_q;
    assign mc_fc_addr = addr_q;

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc (WAYS=2, SETS=64, LINE_WORDS=4).
// Latency: n/a.
// Backpressure: the bench plays the memory controller and pulses done itself.
module tb_icache_assoc;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rdy = 1'b1;
    logic         cache_en = 1'b0;
    logic         cache_st = 1'b0;
    logic         cache_rb = 1'b0;
    logic [31:0]  if_addr = '0;
    logic         if_cache_hit;
    logic [31:0]  if_hit_word;
    logic         mc_fc_ena;
    logic [31:0]  mc_fc_addr;
    logic         mc_fc_done = 1'b0;
    logic [127:0] mc_fc_line = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    icache_assoc #(
        .WAYS(2), .SETS(64), .LINE_WORDS(4), .ADDR_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .cache_en(cache_en), .cache_st(cache_st), .cache_rb(cache_rb),
        .if_addr(if_addr), .if_cache_hit(if_cache_hit), .if_hit_word(if_hit_word),
        .mc_fc_ena(mc_fc_ena), .mc_fc_addr(mc_fc_addr),
        .mc_fc_done(mc_fc_done), .mc_fc_line(mc_fc_line)
    );

    // ---------------- reference model ----------------
    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [127:0] mk_line(input logic [31:0] la);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem_word(la + 32'(4*i));
        return l;
    endfunction

    // Per set: which line address sits in each of the 2 ways, plus the RR pointer.
    bit          m_valid [64][2];
    logic [31:0] m_line  [64][2];
    int          m_ptr   [64];

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 4) % 64);
    endfunction

    task automatic m_reset();
        for (int s = 0; s < 64; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < 2; w++) m_valid[s][w] = 0;
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        int s;
        s = set_of(a);
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_line[s][w] == (a & 32'hFFFF_FFF0)) return 1;
        return 0;
    endfunction

    task automatic m_fill(input logic [31:0] la);
        int s, v;
        s = set_of(la);
        v = -1;
        for (int w = 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
        if (v < 0) begin
            v = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % 2;
        end
        m_valid[s][v] = 1;
        m_line[s][v]  = la;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Starts and ends at posedge+1. Serves a miss like a memory controller with
    // random latency and random rdy bubbles; rb is driven in the done cycle.
    task automatic access(input logic [31:0] a, input bit en, input bit rb);
        logic [31:0] la;
        bit mh;
        int lat;
        la = a & 32'hFFFF_FFF0;
        if_addr = a; cache_en = en; cache_st = 0; cache_rb = 0;
        @(negedge clk);
        mh = m_hit(a);
        check("lookup_hit", 32'(if_cache_hit), 32'(mh));
        check("lookup_word", if_hit_word, mh ? mem_word(a) : 32'h0);
        @(posedge clk); #1;
        if (en && !mh) begin
            cache_en = 0;
            check("req_ena", 32'(mc_fc_ena), 32'h1);
            check("req_addr", mc_fc_addr, la);
            lat = $urandom_range(0, 3);
            repeat (lat) begin
                rdy = 1'($urandom_range(0, 1));
                cache_st = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                rdy = 1;
                check("hold_ena", 32'(mc_fc_ena), 32'h1);
                check("hold_addr", mc_fc_addr, la);
            end
            mc_fc_done = 1; mc_fc_line = mk_line(la); cache_rb = rb;
            @(negedge clk);
            check("prefill_miss", 32'(if_cache_hit), 32'h0);
            @(posedge clk); #1;
            mc_fc_done = 0; cache_rb = 0; cache_st = 0;
            m_fill(la);
            check("ena_fall", 32'(mc_fc_ena), 32'h0);
            @(negedge clk);
            check("postfill_hit", 32'(if_cache_hit), 32'h1);
            check("postfill_word", if_hit_word, mem_word(a));
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; cache_en = 0; cache_st = 0; cache_rb = 0; mc_fc_done = 0; rdy = 1;
        @(posedge clk); #1;
        check("rst_ena", 32'(mc_fc_ena), 32'h0);
        check("rst_addr", mc_fc_addr, 32'h0);
        m_reset();
        rst_n = 1;
    endtask

    // Counts cycles with ena high over n cycles; ends at posedge+1.
    task automatic count_req(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (mc_fc_ena) cnt++;
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          fetch;
        logic [31:0] addr;
        bit          exp_hit;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [31:0] a;

        // ---- reset and first miss/fill (0x1004 -> word D1) ----
        do_reset();
        if_addr = 32'h1004;
        @(negedge clk);
        check("reset_hit", 32'(if_cache_hit), 32'h0);
        check("reset_word", if_hit_word, 32'h0);
        @(posedge clk); #1;
        access(32'h1004, 1, 1);
        if_addr = 32'h1004; cache_en = 0;
        @(negedge clk);
        check("t1_word_D1", if_hit_word, mk_line(32'h1000) >> 32);
        @(posedge clk); #1;

        // ---- round-robin eviction in set 0 ----
        do_reset();
        tbl[0] = '{1, 32'h0000, 0};
        tbl[1] = '{1, 32'h1000, 0};
        tbl[2] = '{1, 32'h2000, 0};
        tbl[3] = '{0, 32'h0000, 0};
        tbl[4] = '{0, 32'h1000, 1};
        tbl[5] = '{1, 32'h3000, 0};
        tbl[6] = '{0, 32'h1000, 0};
        tbl[7] = '{0, 32'h2000, 1};
        tbl[8] = '{0, 32'h3008, 1};
        for (int i = 0; i < 9; i++) begin
            if_addr = tbl[i].addr; cache_en = 0;
            @(negedge clk);
            check($sformatf("tbl%0d_hit", i), 32'(if_cache_hit), 32'(tbl[i].exp_hit));
            check($sformatf("tbl%0d_word", i), if_hit_word,
                  tbl[i].exp_hit ? mem_word(tbl[i].addr) : 32'h0);
            @(posedge clk); #1;
            if (tbl[i].fetch) access(tbl[i].addr, 1, 1);
        end

        // ---- stall blocks issue ----
        if_addr = 32'h5000; cache_en = 1; cache_st = 1;
        repeat (2) begin
            @(posedge clk); #1;
            check("stall_no_issue", 32'(mc_fc_ena), 32'h0);
        end
        cache_en = 0; cache_st = 0;

        // ---- fill completes during a 5-cycle stall, done on cycle 3 ----
        if_addr = 32'h4008; cache_en = 1;
        @(posedge clk); #1;
        check("st_req", 32'(mc_fc_ena), 32'h1);
        check("st_addr", mc_fc_addr, 32'h4000);
        cache_st = 1;
        repeat (2) begin
            @(posedge clk); #1;
            check("st_hold", 32'(mc_fc_ena), 32'h1);
        end
        mc_fc_done = 1; mc_fc_line = mk_line(32'h4000); cache_rb = 1;
        @(negedge clk);
        check("st_prefill", 32'(if_cache_hit), 32'h0);
        @(posedge clk); #1;
        mc_fc_done = 0; cache_rb = 0;
        m_fill(32'h4000);
        check("st_ena_fall", 32'(mc_fc_ena), 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("st_hit_stalled", 32'(if_cache_hit), 32'h1);
            @(posedge clk); #1;
            check("st_no_reissue", 32'(mc_fc_ena), 32'h0);
        end
        cache_st = 0;
        @(negedge clk);
        check("st_release_word", if_hit_word, mem_word(32'h4008));
        @(posedge clk); #1;
        check("st_release_ena", 32'(mc_fc_ena), 32'h0);
        cache_en = 0;

        // ---- rdy=0 freezes, async reset mid-fetch ----
        if_addr = 32'h6000; cache_en = 1; rdy = 0;
        @(posedge clk); #1;
        check("rdy0_no_issue", 32'(mc_fc_ena), 32'h0);
        rdy = 1;
        @(posedge clk); #1;
        cache_en = 0;
        check("rdy_req", 32'(mc_fc_ena), 32'h1);
        rdy = 0;
        repeat (3) begin
            @(posedge clk); #1;
            check("rdy0_ena", 32'(mc_fc_ena), 32'h1);
            check("rdy0_addr", mc_fc_addr, 32'h6000);
        end
        rdy = 1;
        #2;
        rst_n = 0;
        #1;
        check("arst_ena", 32'(mc_fc_ena), 32'h0);
        check("arst_addr", mc_fc_addr, 32'h0);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 32'h2000 : (i == 1) ? 32'h3000 : 32'h4008;
            if_addr = a;
            @(negedge clk);
            check("arst_miss", 32'(if_cache_hit), 32'h0);
            @(posedge clk); #1;
        end

`ifdef ICACHE_PREFETCH_EN
        // ---- next-line prefetch ----
        do_reset();
        access(32'h1000, 1, 0);
        check("pf_req_ena", 32'(mc_fc_ena), 32'h1);
        check("pf_req_addr", mc_fc_addr, 32'h1010);
        mc_fc_done = 1; mc_fc_line = mk_line(32'h1010);
        @(posedge clk); #1;
        mc_fc_done = 0;
        m_fill(32'h1010);
        check("pf_ena_fall", 32'(mc_fc_ena), 32'h0);
        if_addr = 32'h1014;
        @(negedge clk);
        check("pf_hit", 32'(if_cache_hit), 32'h1);
        check("pf_word", if_hit_word, mem_word(32'h1014));
        @(posedge clk); #1;
        do_reset();
        access(32'h1000, 1, 1);
        count_req(8, cnt);
        check("pf_rb_count", 32'(cnt), 32'h0);
`else
        // ---- no prefetch: one request only, back in IDLE ----
        do_reset();
        access(32'h1000, 1, 0);
        count_req(8, cnt);
        check("nopf_count", 32'(cnt), 32'h0);
        access(32'h2000, 1, 1);
`endif

        // ---- randomized accesses against the model ----
        do_reset();
        for (int i = 0; i < 150; i++) begin
            a = (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            access(a, $urandom_range(0, 4) != 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
